// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out serializer.
// The PARITY state only exists when PISO_PARITY_EN is defined.
package piso_pkg;

  localparam int PISO_DEFAULT_SIZE = 4;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;
`endif

  // Bit-index counter width; a one-bit word still needs a one-bit counter.
  function automatic int piso_cnt_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking the remaining data bits of a frame.
// Saturates at zero and reports it through the zero flag.
module piso_bit_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-in serial-out serializer with back-to-back frame support.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int SIZE = PISO_DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] din,
  input  logic            load,
  output logic            ready,
  output logic            d,
  output logic            valid,
  output logic            done
);

  localparam int              CW       = piso_cnt_width(SIZE);
  localparam logic [CW-1:0]   LAST_IDX = CW'(SIZE - 1);

  piso_state_e     state_q, state_d;
  logic [SIZE-1:0] shift_q, shift_d;
  logic            cnt_zero;
  logic            accept;
  logic            last_bit;
`ifdef PISO_PARITY_EN
  logic            parity_q, parity_d;
`endif

  piso_bit_counter #(
    .WIDTH(CW)
  ) u_bit_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_value(LAST_IDX),
    .dec       (state_q == ST_SHIFT),
    .zero      (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_zero) begin
`ifdef PISO_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        state_d = accept ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // A new word may be taken on the last frame bit, so the next frame follows with no gap.
  always_comb begin
    valid    = 1'b0;
    d        = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        valid = 1'b1;
        d     = shift_q[SIZE-1];
`ifndef PISO_PARITY_EN
        last_bit = cnt_zero;
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        valid    = 1'b1;
        d        = parity_q;
        last_bit = 1'b1;
      end
`endif
      default: begin
        valid = 1'b0;
      end
    endcase
    done   = last_bit;
    ready  = !reset && ((state_q == ST_IDLE) || last_bit);
    accept = load && ready;
  end

  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      shift_d = din;
    end else if (state_q == ST_SHIFT) begin
      shift_d = shift_q << 1;
    end
  end

`ifdef PISO_PARITY_EN
  always_comb begin
    parity_d = parity_q;
    if (accept) parity_d = ^din;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (SIZE=4 main instance, SIZE=1 side instance).
// Honours PISO_PARITY_EN in its reference model.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = 4 + (PAR ? 1 : 0);

  typedef struct {
    logic       bit_val;
    logic       last;
    logic [3:0] word;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic       load;
  logic       ready, d, valid, done;

  logic       din1, load1;
  logic       ready1, d1, valid1, done1;

  exp_t       exp_q[$];
  logic       exp_ready;
  int         rem;
  int         tests;
  int         fails;
  int         frames;
  logic [7:0] hist;

  piso_serializer #(.SIZE(4)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .load (load),
    .ready(ready),
    .d    (d),
    .valid(valid),
    .done (done)
  );

  piso_serializer #(.SIZE(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .din  (din1),
    .load (load1),
    .ready(ready1),
    .d    (d1),
    .valid(valid1),
    .done (done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // One clock cycle of stimulus; the model decides acceptance from frame occupancy alone.
  task automatic step(input logic l, input logic [3:0] w, input logic r);
    load      = l;
    din       = w;
    reset     = r;
    exp_ready = !r && (rem <= 1);
    @(posedge clk);
    if (r) begin
      rem = 0;
      exp_q.delete();
    end else if (l && exp_ready) begin
      for (int i = 3; i >= 0; i--) begin
        exp_q.push_back('{bit_val: w[i], last: (i == 0) && !PAR, word: w});
      end
      if (PAR) exp_q.push_back('{bit_val: ^w, last: 1'b1, word: w});
      rem = FRAME;
    end else if (rem > 0) begin
      rem = rem - 1;
    end
    #1;
  endtask

  // Monitor: compares every cycle's outputs against the scoreboard queue.
  initial begin
    exp_t e;
    hist = '0;
    forever begin
      @(negedge clk);
      check("ready", ready, exp_ready);
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", valid, 1'b0);
        end else begin
          e    = exp_q.pop_front();
          hist = {hist[6:0], d};
          check("d", d, e.bit_val);
          check("done", done, e.last);
          if (e.last) begin
            frames++;
            check("sipo_word", PAR ? hist[4:1] : hist[3:0], e.word);
            $display("[TB] frame %0d word=%h serial=%b", frames, e.word, hist[FRAME-1:0]);
          end
        end
      end else begin
        check("idle_d", d, 1'b0);
        check("idle_done", done, 1'b0);
        check("no_gap", exp_q.size(), 0);
      end
    end
  end

  initial begin
    tests     = 0;
    fails     = 0;
    frames    = 0;
    rem       = 0;
    reset     = 1'b1;
    load      = 1'b0;
    din       = 4'h0;
    load1     = 1'b0;
    din1      = 1'b0;
    exp_ready = 1'b0;

    step(1'b1, 4'hF, 1'b1);
    step(1'b0, 4'h0, 1'b1);

    // Single frame 1011, with idle tail
    step(1'b1, 4'hB, 1'b0);
    repeat (FRAME + 1) step(1'b0, 4'h0, 1'b0);

    // Back-to-back A then 5
    step(1'b1, 4'hA, 1'b0);
    repeat (FRAME - 1) step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    repeat (FRAME + 1) step(1'b0, 4'h0, 1'b0);

    // Loads while busy are ignored
    step(1'b1, 4'hC, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    repeat (FRAME) step(1'b0, 4'h0, 1'b0);

    // Reset mid-frame
    step(1'b1, 4'hF, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    repeat (3) step(1'b0, 4'h0, 1'b0);

    // Parity value case
    step(1'b1, 4'h9, 1'b0);
    repeat (FRAME + 1) step(1'b0, 4'h0, 1'b0);

    // One-bit word on the SIZE=1 instance
    load1 = 1'b1;
    din1  = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    load1 = 1'b0;
    @(negedge clk);
    check("s1_valid", valid1, 1'b1);
    check("s1_d", d1, 1'b1);
    check("s1_done", done1, !PAR);
    check("s1_ready", ready1, !PAR);
    step(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    check("s1_valid2", valid1, PAR);
    check("s1_d2", d1, PAR);
    check("s1_done2", done1, PAR);
    check("s1_ready2", ready1, 1'b1);
    repeat (2) step(1'b0, 4'h0, 1'b0);

    // Randomized traffic with occasional resets
    repeat (400) begin
      step($urandom_range(0, 2) != 0, 4'($urandom), $urandom_range(0, 49) == 0);
    end
    repeat (FRAME + 2) step(1'b0, 4'h0, 1'b0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
